// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the ID/EX stage and the iterative
// multiply/divide unit.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] data_1_in;
    logic [XLEN-1:0] data_2_in;
    logic [4:0]      Rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result_out;
    logic [4:0]      Rd_out;

    // Pipeline side: issues operations and consumes results.
    modport master (
        output start, op, data_1_in, data_2_in, Rd_in, flush,
        input  busy, done, result_out, Rd_out
    );

    // Execution unit side.
    modport slave (
        input  start, op, data_1_in, data_2_in, Rd_in, flush,
        output busy, done, result_out, Rd_out
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit. One bit per cycle: radix-2
// shift-add multiply and restoring divide, both on operand magnitudes,
// with the sign applied in a single fix-up cycle before the result is
// registered. Divide-by-zero and signed overflow bypass the iterations.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    ex_muldiv_if.slave bus
);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [5:0]        r_count;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic              r_neg;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    logic              w_accept;
    logic              w_a_sign;
    logic              w_b_sign;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg_in;
    logic              w_special;
    logic [2*XLEN-1:0] w_special_acc;

    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_acc;
    logic [XLEN:0]     w_rem_shift;
    logic              w_rem_ge;
    logic [XLEN-1:0]   w_rem_diff;
    logic [2*XLEN-1:0] w_div_acc;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.flush;
    assign w_a_sign = bus.data_1_in[XLEN-1];
    assign w_b_sign = bus.data_2_in[XLEN-1];
    assign w_a_abs  = w_a_sign ? (ZERO - bus.data_1_in) : bus.data_1_in;
    assign w_b_abs  = w_b_sign ? (ZERO - bus.data_2_in) : bus.data_2_in;

    // Operand magnitudes, result sign and divide special cases for the issuing op.
    always_comb begin
        w_a_mag       = bus.data_1_in;
        w_b_mag       = bus.data_2_in;
        w_neg_in      = 1'b0;
        w_special     = 1'b0;
        w_special_acc = '0;
        case (bus.op)
            OP_MUL, OP_MULH, OP_DIV: begin
                w_a_mag  = w_a_abs;
                w_b_mag  = w_b_abs;
                w_neg_in = w_a_sign ^ w_b_sign;
            end
            OP_MULHSU: begin
                w_a_mag  = w_a_abs;
                w_neg_in = w_a_sign;
            end
            OP_REM: begin
                w_a_mag  = w_a_abs;
                w_b_mag  = w_b_abs;
                w_neg_in = w_a_sign;
            end
            default: ;
        endcase
        // Quotient lives in the low half, remainder in the high half, so one
        // preloaded accumulator serves both the DIV and REM flavours.
        if (bus.op[2] && (bus.data_2_in == ZERO)) begin
            w_special     = 1'b1;
            w_special_acc = {bus.data_1_in, ALL_ONES};
        end else if ((bus.op == OP_DIV || bus.op == OP_REM) &&
                     (bus.data_1_in == MIN_NEG) && (bus.data_2_in == ALL_ONES)) begin
            w_special     = 1'b1;
            w_special_acc = {ZERO, MIN_NEG};
        end
    end

    // One shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {1'b0, ZERO});
    assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

    // One restoring step: the partial remainder is shifted with one extra bit
    // so a remainder with its MSB set is not lost before the compare.
    assign w_rem_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_opnd});
    assign w_rem_diff  = w_rem_shift[XLEN-1:0] - r_opnd;
    assign w_div_acc   = w_rem_ge ? {w_rem_diff, r_acc[XLEN-2:0], 1'b1}
                                  : {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    // Sign fix-up and result selection for the completed operation.
    assign w_prod = r_neg ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
    assign w_quot = r_neg ? (ZERO - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? (ZERO - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

    // Pick the final result word from product, quotient or remainder.
    always_comb begin
        w_result = w_prod[XLEN-1:0];
        case (r_op)
            OP_MUL:                        w_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_result = w_quot;
            OP_REM, OP_REMU:               w_result = w_rem;
            default:                       w_result = w_prod[XLEN-1:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush wins over everything, including a new start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    w_state_next = IDLE;
                end else if (r_count == 6'(XLEN-1)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and registered result/handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.op;
                        r_rd    <= bus.Rd_in;
                        r_count <= '0;
                        if (w_special) begin
                            r_acc  <= w_special_acc;
                            r_opnd <= ZERO;
                            r_neg  <= 1'b0;
                        end else if (bus.op[2]) begin
                            r_acc  <= {ZERO, w_a_mag};
                            r_opnd <= w_b_mag;
                            r_neg  <= w_neg_in;
                        end else begin
                            r_acc  <= {ZERO, w_b_mag};
                            r_opnd <= w_a_mag;
                            r_neg  <= w_neg_in;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        r_acc   <= r_op[2] ? w_div_acc : w_mul_acc;
                        r_count <= r_count + 6'd1;
                    end
                end
                DONE: begin
                    if (!bus.flush) begin
                        r_result <= w_result;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.result_out = r_result;
    assign bus.Rd_out     = r_rd_out;

    // The upstream stall must keep new issues away while an op is in flight.
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!reset) !(bus.start && r_busy)
    ) else $error("start issued while busy");

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit for the execute stage, directly downstream of the ID/EX pipeline register. It consumes the register operands and destination register of an M-extension instruction. It computes the result over multiple cycles and raises `busy` so the hazard logic holds IF/ID and drives the stall input of ID/EX, which inserts a bubble. The result and destination are presented for one cycle with `done` for the EX/MEM mux.

## Interface
Parameters:
- XLEN, 32, operand/result width (only 32 supported)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  issue request; op valid this cycle
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- data_1_in  in  32  rs1 value (post-forwarding)
- data_2_in  in  32  rs2 value (post-forwarding)
- Rd_in  in  5  destination register
- flush  in  1  synchronous kill of in-flight op (branch redirect)
- busy  out  1  operation in flight; stall request
- done  out  1  one-cycle result-valid pulse
- result_out  out  32  result, valid when done=1
- Rd_out  out  5  destination, valid when done=1

## Operation
- States: IDLE, CALC, DONE. Registers: 6-bit iteration counter, 64-bit product/remainder accumulator, 32-bit operand shadow, op/Rd latches, neg_result flag.
- Reset (reset=0, async): state=IDLE; busy=0, done=0, result_out=0, Rd_out=0, counter=0, accumulator=0.
- IDLE: start=1 latches op, Rd_in and operand magnitudes; goes to CALC, or directly to DONE for a divide special case. start=0: stay.
- Signed handling: DIV/REM/MULH take absolute values of both operands. MULHSU negates rs1 only. neg_result is set as follows:
  - MUL/MULH: sign(rs1) XOR sign(rs2).
  - MULHSU: sign(rs1).
  - DIV: sign(rs1) XOR sign(rs2).
  - REM: sign(rs1).
  - Unsigned ops: 0.
- CALC multiply: radix-2 shift-add, one bit per cycle, 32 iterations, 64-bit unsigned product.
- CALC divide: restoring, one quotient bit per cycle, 32 iterations.
- Counter runs 0..31; on count 31 go to DONE.
- DONE (fix-up): two's-complement negate if neg_result. MUL selects product[31:0]. MULH/MULHSU/MULHU select product[63:32] of the signed 64-bit value. DIV/DIVU select the quotient; REM/REMU select the remainder. Register result_out and Rd_out, pulse done, go to IDLE.
- Divide by zero (rs2=0), decided at start:
  - DIV/DIVU: quotient=0xFFFFFFFF.
  - REM/REMU: remainder=rs1.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- start while busy=1 is ignored. The upstream stall guarantees it does not occur; assertions flag it.
- flush=1 in CALC or DONE: go to IDLE at the next edge. No done pulse; result_out/Rd_out are unchanged. flush has priority over start in the same cycle.
- Rd_in=0 is processed normally; writeback suppression is downstream's job.

## Timing
- E0 = edge sampling start=1 in IDLE.
- Normal ops: iterations at E1..E32, fix-up at E33. busy=1 from after E0 until E33; done=1 and result valid for exactly the cycle after E33, with busy=0 in that cycle.
- Special divide cases: fix-up at E1; busy=1 for one cycle (E0..E1); done=1 the cycle after E1.
- Back-to-back: start may be asserted in the done cycle. It is accepted at that cycle's edge, with no idle gap.
- done is never asserted while busy=1. Outputs are registered; busy is not combinational from start.
- Async reset mid-CALC: all outputs clear immediately, and no done pulse follows release. The first start after release is a normal E0.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), Rd=5 → busy high 33 cycles; done after E33 with result 0xFFFFFFEB, Rd_out=5.
- MULH/MULHSU/MULHU with 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV −7/2, REM −7/2, DIVU 100/7, REMU 100/7 → 0xFFFFFFFD, 0xFFFFFFFF, 14, 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, DIV 0x80000000/−1 → 0x80000000; each with done 2 cycles after start edge.
- flush at E10 of DIVU → no done pulse, busy=0 after E11. Then start in the same cycle as a second flush → ignored. A later start → correct result.
- reset=0 asserted at E20 of MUL 3×4 → outputs 0 immediately. After release, MUL 3×4 → done after E33 with 12; back-to-back start in the done cycle accepted.
